// File: rtl/fila_copias.sv
// Copy-job queue feeding the copier FSM: switch edges become jobs in a show-ahead FIFO.
// Optional input debouncer enabled by defining FILA_DEBOUNCE_EN.
module fila_copias #(
    parameter int DEPTH      = 4,
    parameter int QBITS      = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic                         clk_2,
    input  logic                         reset,
    input  logic                         copiar,
    input  logic [QBITS-1:0]             quantidade,
    input  logic                         job_ready,
    output logic                         job_valid,
    output logic [QBITS-1:0]             job_qtd,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         full,
    output logic                         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEB_CYCLES < 1) begin : g_bad_param
        $error("fila_copias: DEPTH must be a power of 2 >= 2 and DEB_CYCLES >= 1");
    end

    logic             copiar_lvl;
    logic             copiar_q;
    logic             req;
    logic             push;
    logic             pop;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [QBITS-1:0] mem [DEPTH];

`ifdef FILA_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] deb_cnt;

    // The filtered level follows copiar only after DEB_CYCLES identical samples in a row.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            copiar_lvl <= 1'b1;
            deb_cnt    <= '0;
        end else if (copiar == copiar_lvl) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
            copiar_lvl <= copiar;
            deb_cnt    <= '0;
        end else begin
            deb_cnt <= deb_cnt + CW'(1);
        end
    end
`else
    assign copiar_lvl = copiar;
`endif

    assign full      = (pending == PW'(DEPTH));
    assign job_valid = (pending != '0);
    assign job_qtd   = job_valid ? mem[rd_ptr] : '0;
    assign req       = copiar_lvl & ~copiar_q;
    assign pop       = job_valid & job_ready;
    // A pop frees a slot in this same cycle, so a full queue can still accept.
    assign push      = req & (quantidade != '0) & (~full | pop);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            copiar_q <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= '0;
            drop     <= 1'b0;
        end else begin
            copiar_q <= copiar_lvl;
            drop     <= req & ((quantidade == '0) | (full & ~pop));
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                pending <= pending + PW'(1);
            end else if (pop && !push) begin
                pending <= pending - PW'(1);
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (push) begin
            mem[wr_ptr] <= quantidade;
        end
    end

endmodule

// File: tb/tb_fila_copias.sv
// Directed self-checking bench for fila_copias; the debounce scenario runs when FILA_DEBOUNCE_EN is defined.
module tb_fila_copias;

    localparam int DEPTH      = 4;
    localparam int QBITS      = 2;
    localparam int DEB_CYCLES = 4;
    localparam int PW         = $clog2(DEPTH+1);
`ifdef FILA_DEBOUNCE_EN
    localparam int SETTLE = DEB_CYCLES + 1;
`else
    localparam int SETTLE = 1;
`endif

    logic             clk_2 = 1'b0;
    logic             reset;
    logic             copiar;
    logic [QBITS-1:0] quantidade;
    logic             job_ready;
    logic             job_valid;
    logic [QBITS-1:0] job_qtd;
    logic [PW-1:0]    pending;
    logic             full;
    logic             drop;

    int errors = 0;
    int checks = 0;

    fila_copias #(.DEPTH(DEPTH), .QBITS(QBITS), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .copiar     (copiar),
        .quantidade (quantidade),
        .job_ready  (job_ready),
        .job_valid  (job_valid),
        .job_qtd    (job_qtd),
        .pending    (pending),
        .full       (full),
        .drop       (drop)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Raise the switch; the request is taken on the last tick (job_ready optionally high only then).
    task automatic raiseCopiar(input logic [QBITS-1:0] q, input logic ready_at_req);
        copiar     = 1'b1;
        quantidade = q;
        repeat (SETTLE - 1) tick();
        job_ready = ready_at_req;
        tick();
        job_ready = 1'b0;
    endtask

    task automatic lowerCopiar();
        copiar = 1'b0;
        repeat (SETTLE) tick();
    endtask

    task automatic applyStimulus(input logic [QBITS-1:0] q);
        raiseCopiar(q, 1'b0);
        lowerCopiar();
    endtask

    initial begin
        reset      = 1'b1;
        copiar     = 1'b1;
        quantidade = '0;
        job_ready  = 1'b0;
        tick();
        tick();
        checkOutput("rst_pending", 32'(pending), 0);
        checkOutput("rst_valid", 32'(job_valid), 0);
        checkOutput("rst_qtd", 32'(job_qtd), 0);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_drop", 32'(drop), 0);

        // Switch held high through reset release must not create a job.
        reset = 1'b0;
        repeat (SETTLE + 3) tick();
        checkOutput("held_pending", 32'(pending), 0);
        checkOutput("held_valid", 32'(job_valid), 0);
        checkOutput("held_drop", 32'(drop), 0);

        // Ready while empty is ignored.
        lowerCopiar();
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        checkOutput("empty_ready_pending", 32'(pending), 0);

        // Three jobs, then drain in order.
        copiar     = 1'b1;
        quantidade = 2'd3;
        #1;
        checkOutput("no_bypass_valid", 32'(job_valid), 0);
        repeat (SETTLE) tick();
        checkOutput("first_push_valid", 32'(job_valid), 1);
        checkOutput("first_push_qtd", 32'(job_qtd), 3);
        lowerCopiar();
        applyStimulus(2'd1);
        applyStimulus(2'd2);
        checkOutput("three_pending", 32'(pending), 3);
        checkOutput("three_head", 32'(job_qtd), 3);
        job_ready = 1'b1;
        checkOutput("drain_0", 32'(job_qtd), 3);
        tick();
        checkOutput("drain_1", 32'(job_qtd), 1);
        tick();
        checkOutput("drain_2", 32'(job_qtd), 2);
        tick();
        job_ready = 1'b0;
        checkOutput("drained_pending", 32'(pending), 0);
        checkOutput("drained_valid", 32'(job_valid), 0);
        checkOutput("drained_qtd", 32'(job_qtd), 0);

        // Fill, then one request too many.
        applyStimulus(2'd1);
        applyStimulus(2'd2);
        applyStimulus(2'd3);
        applyStimulus(2'd1);
        checkOutput("fill_pending", 32'(pending), 4);
        checkOutput("fill_full", 32'(full), 1);
        raiseCopiar(2'd2, 1'b0);
        checkOutput("overflow_drop", 32'(drop), 1);
        checkOutput("overflow_pending", 32'(pending), 4);
        checkOutput("overflow_head", 32'(job_qtd), 1);
        copiar = 1'b0;
        tick();
        checkOutput("overflow_drop_clear", 32'(drop), 0);
        repeat (SETTLE - 1) tick();

        // Full with a simultaneous pop: new job lands behind the three older ones.
        raiseCopiar(2'd2, 1'b1);
        checkOutput("fullpop_pending", 32'(pending), 4);
        checkOutput("fullpop_drop", 32'(drop), 0);
        copiar    = 1'b0;
        job_ready = 1'b1;
        checkOutput("order_0", 32'(job_qtd), 2);
        tick();
        checkOutput("order_1", 32'(job_qtd), 3);
        tick();
        checkOutput("order_2", 32'(job_qtd), 1);
        tick();
        checkOutput("order_3_new", 32'(job_qtd), 2);
        tick();
        job_ready = 1'b0;
        checkOutput("order_empty", 32'(job_valid), 0);
        repeat (SETTLE) tick();

        // Zero quantity is rejected.
        raiseCopiar(2'd0, 1'b0);
        checkOutput("zero_drop", 32'(drop), 1);
        checkOutput("zero_pending", 32'(pending), 0);
        lowerCopiar();
        checkOutput("zero_drop_clear", 32'(drop), 0);

        // Reset discards queued jobs.
        applyStimulus(2'd3);
        applyStimulus(2'd1);
        checkOutput("prereset_pending", 32'(pending), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_pending", 32'(pending), 0);
        checkOutput("midreset_valid", 32'(job_valid), 0);
        lowerCopiar();

`ifdef FILA_DEBOUNCE_EN
        lowerCopiar();
        copiar = 1'b1;
        repeat (3) tick();
        copiar = 1'b0;
        repeat (2 * SETTLE) tick();
        checkOutput("deb_short_pulse", 32'(pending), 0);
        quantidade = 2'd2;
        copiar = 1'b1;
        tick();
        copiar = 1'b0;
        tick();
        copiar = 1'b1;
        repeat (DEB_CYCLES) tick();
        checkOutput("deb_not_yet", 32'(pending), 0);
        tick();
        checkOutput("deb_pushed", 32'(pending), 1);
        repeat (DEB_CYCLES) tick();
        copiar = 1'b0;
        repeat (2 * SETTLE) tick();
        checkOutput("deb_once", 32'(pending), 1);
        checkOutput("deb_qtd", 32'(job_qtd), 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
